// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB writeback stage: load kinds, buffer states and the
// register-file write-port record.
package wb_pkg;
    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LH  = 3'd1,
        LT_LHU = 3'd2,
        LT_LB  = 3'd3,
        LT_LBU = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_HELD    = 2'd1,
        BUF_STARVED = 2'd2
    } buf_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        we;
    } wr_port_t;
endpackage

// File: rtl/writeback_unit_load_extend.sv
// Combinational load alignment: picks the byte/half addressed by addr_low from an
// aligned little-endian word and sign- or zero-extends it.
module load_extend
    import wb_pkg::*;
(
    input  load_type_e  load_type,
    input  logic [1:0]  addr_low,
    input  logic [31:0] read_data,
    output logic [31:0] value
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = read_data[8*addr_low +: 8];
        half_sel = addr_low[1] ? read_data[31:16] : read_data[15:0];
        case (load_type)
            LT_LH:   value = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  value = {16'd0, half_sel};
            LT_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  value = {24'd0, byte_sel};
            default: value = read_data;
        endcase
    end
endmodule

// File: rtl/writeback_unit.sv
// MEM/WB stage: sole writer of the register-file port. Main-path results win every
// used slot; a one-entry buffer slips mult/div completions into free slots.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter bit TRACE_EN     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_we,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic        mem_isLoad,
    input  logic [2:0]  mem_loadType,
    input  logic [1:0]  mem_addrLow,
    input  logic [31:0] mem_readData,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_dest,
    input  logic [31:0] md_pc,
    input  logic [31:0] md_data,
    output logic [31:0] programCounter,
    output logic        writeEnabled,
    output logic [4:0]  registerId,
    output logic [31:0] writeInput,
    output logic        stall_req,
    output logic        md_squash
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    buf_state_e  state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [4:0]  b_dest;
    logic [31:0] b_data, b_pc;
    logic        live;
    wr_port_t    wr_q, wr_d;
    logic        squash_q, squash_d;
    logic        main_use, md_xfer, hit;
    logic [31:0] ld_val, main_data;

    load_extend u_ext (
        .load_type (load_type_e'(mem_loadType)),
        .addr_low  (mem_addrLow),
        .read_data (mem_readData),
        .value     (ld_val)
    );

    // live keeps md_ready low through reset and its release cycle
    assign main_use  = mem_valid && mem_we && (mem_dest != REG_ZERO);
    assign hit       = (state != BUF_EMPTY) && main_use && (mem_dest == b_dest);
    assign md_ready  = live && (state == BUF_EMPTY);
    assign md_xfer   = md_valid && md_ready;
    assign main_data = mem_isLoad ? ld_val : mem_result;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_d     = '0;
        squash_d = 1'b0;
        if (main_use)
            wr_d = '{pc: mem_pc, dest: mem_dest, data: main_data, we: 1'b1};
        case (state)
            BUF_EMPTY: begin
                if (md_xfer) begin
                    state_nx = BUF_HELD;
                    cnt_nx   = '0;
                end
            end
            default: begin
                if (hit) begin
                    // newer main write to the same register makes the entry stale
                    state_nx = BUF_EMPTY;
                    cnt_nx   = '0;
                    squash_d = 1'b1;
                end else if (!main_use) begin
                    wr_d     = '{pc: b_pc, dest: b_dest, data: b_data, we: 1'b1};
                    state_nx = BUF_EMPTY;
                    cnt_nx   = '0;
                end else begin
                    if (cnt != LIMIT)
                        cnt_nx = cnt + CW'(1);
                    if (cnt_nx == LIMIT)
                        state_nx = BUF_STARVED;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= BUF_EMPTY;
            cnt      <= '0;
            live     <= 1'b0;
            b_dest   <= '0;
            b_data   <= '0;
            b_pc     <= '0;
            wr_q     <= '0;
            squash_q <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            live     <= 1'b1;
            wr_q     <= wr_d;
            squash_q <= squash_d;
            if (md_xfer) begin
                b_dest <= md_dest;
                b_data <= md_data;
                b_pc   <= md_pc;
            end
        end
    end

    assign writeEnabled   = wr_q.we;
    assign registerId     = wr_q.dest;
    assign writeInput     = wr_q.data;
    assign programCounter = TRACE_EN ? wr_q.pc : 32'd0;
    assign stall_req      = (state == BUF_STARVED);
    assign md_squash      = squash_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, all checked
// against a slot-level reference model of the writeback rules.
module tb_writeback_unit;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid, mem_we, mem_isLoad, md_valid;
    logic [31:0] mem_pc, mem_result, mem_readData, md_pc, md_data;
    logic [4:0]  mem_dest, md_dest;
    logic [2:0]  mem_loadType;
    logic [1:0]  mem_addrLow;
    logic        md_ready, writeEnabled, stall_req, md_squash;
    logic [4:0]  registerId;
    logic [31:0] programCounter, writeInput;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          m_have, m_live;
    logic [4:0]  m_dest;
    logic [31:0] m_data, m_pc;
    int          m_wait;
    bit          e_we, e_sq, e_stall, e_ready;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_pc;

    writeback_unit #(.STARVE_LIMIT(LIMIT), .TRACE_EN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_we(mem_we), .mem_dest(mem_dest),
        .mem_result(mem_result), .mem_isLoad(mem_isLoad), .mem_loadType(mem_loadType),
        .mem_addrLow(mem_addrLow), .mem_readData(mem_readData),
        .md_valid(md_valid), .md_ready(md_ready), .md_dest(md_dest), .md_pc(md_pc),
        .md_data(md_data), .programCounter(programCounter), .writeEnabled(writeEnabled),
        .registerId(registerId), .writeInput(writeInput), .stall_req(stall_req),
        .md_squash(md_squash)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (lt)
            3'd1, 3'd2: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (lt == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            3'd3, 3'd4: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (lt == 3'd3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [72:0] dut_word();
        return {writeEnabled, registerId, writeInput, programCounter, md_squash,
                stall_req, md_ready};
    endfunction

    function automatic logic [72:0] mdl_word();
        return {e_we, e_rd, e_wd, e_pc, e_sq, e_stall, e_ready};
    endfunction

    task automatic model_reset();
        m_have = 0; m_live = 0; m_wait = 0;
        e_we = 0; e_rd = 0; e_wd = 0; e_pc = 0; e_sq = 0; e_stall = 0; e_ready = 0;
    endtask

    // one clock: predict what the slot produces, then advance the DUT
    task automatic step();
        bit main, ready_now;
        main      = mem_valid && mem_we && (mem_dest != 0);
        ready_now = m_live && !m_have;
        e_we = 0; e_rd = 0; e_wd = 0; e_pc = 0; e_sq = 0;
        if (main) begin
            e_we = 1; e_rd = mem_dest; e_pc = mem_pc;
            e_wd = mem_isLoad ? ref_load(mem_loadType, mem_addrLow, mem_readData) : mem_result;
        end
        if (m_have) begin
            if (main && mem_dest == m_dest) begin
                m_have = 0; e_sq = 1;
            end else if (!main) begin
                e_we = 1; e_rd = m_dest; e_wd = m_data; e_pc = m_pc; m_have = 0;
            end else begin
                m_wait++;
            end
        end else if (md_valid && ready_now) begin
            m_have = 1; m_dest = md_dest; m_data = md_data; m_pc = md_pc; m_wait = 0;
        end
        m_live  = 1;
        e_stall = m_have && (m_wait >= LIMIT);
        e_ready = m_live && !m_have;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        mem_valid = 0; mem_we = 0; mem_dest = 0; mem_result = 0; mem_isLoad = 0;
        mem_loadType = 0; mem_addrLow = 0; mem_readData = 0; mem_pc = 0;
        md_valid = 0; md_dest = 0; md_pc = 0; md_data = 0;
    endtask

    task automatic alu(input logic [4:0] d, input logic [31:0] r, input logic [31:0] pc);
        mem_valid = 1; mem_we = 1; mem_dest = d; mem_result = r; mem_isLoad = 0; mem_pc = pc;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if (dut_word() !== 73'd0) begin
            n_bad++; $display("FAIL reset_state: got %h want 0", dut_word());
        end
        reset = 1;
        step();
        n_cmp++;
        if (dut_word() !== mdl_word()) begin
            n_bad++; $display("FAIL reset_release: got %h want %h", dut_word(), mdl_word());
        end
    endtask

    task automatic test_alu();
        alu(5'd8, 32'h1234, 32'h100);
        step();
        idle();
        n_cmp++;
        if ({writeEnabled, registerId, writeInput} !== {1'b1, 5'd8, 32'h1234}) begin
            n_bad++; $display("FAIL alu_write: got we=%0b rd=%0d wd=%h want 1/8/1234",
                              writeEnabled, registerId, writeInput);
        end
        n_cmp++;
        if (dut_word() !== mdl_word()) begin
            n_bad++; $display("FAIL alu_model: got %h want %h", dut_word(), mdl_word());
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lt [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
        logic [1:0]  ad [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
        logic [31:0] ex [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
        for (int i = 0; i < 4; i++) begin
            alu(5'd12, 32'hDEAD_BEEF, 32'h200 + 32'(i));
            mem_isLoad = 1; mem_loadType = lt[i]; mem_addrLow = ad[i];
            mem_readData = 32'h80FF_7F01;
            step();
            n_cmp++;
            if (writeInput !== ex[i] || writeEnabled !== 1'b1) begin
                n_bad++; $display("FAIL load_%0d: got we=%0b wd=%h want 1/%h",
                                  i, writeEnabled, writeInput, ex[i]);
            end
        end
        idle();
        mem_valid = 1; mem_we = 1; mem_dest = 5'd13; mem_isLoad = 1; mem_loadType = 3'd0;
        mem_addrLow = 2'd3; mem_readData = 32'hCAFE_F00D;
        step();
        idle();
        n_cmp++;
        if (writeInput !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL load_lw: got %h want cafef00d", writeInput);
        end
    endtask

    task automatic test_zero_dest();
        alu(5'd0, 32'h77, 32'h300);
        step();
        n_cmp++;
        if (writeEnabled !== 1'b0) begin
            n_bad++; $display("FAIL zero_no_write: got we=%0b want 0", writeEnabled);
        end
        // park an md entry, then let a $0 write free the slot
        alu(5'd3, 32'h33, 32'h304);
        md_valid = 1; md_dest = 5'd6; md_data = 32'h66; md_pc = 32'h900;
        step();
        md_valid = 0;
        alu(5'd0, 32'h11, 32'h308);
        step();
        idle();
        n_cmp++;
        if ({writeEnabled, registerId, writeInput, programCounter} !==
            {1'b1, 5'd6, 32'h66, 32'h900}) begin
            n_bad++; $display("FAIL zero_drain: got we=%0b rd=%0d wd=%h pc=%h want 1/6/66/900",
                              writeEnabled, registerId, writeInput, programCounter);
        end
    endtask

    task automatic test_arbitration();
        int waited;
        alu(5'd10, 32'h1, 32'h400);
        md_valid = 1; md_dest = 5'd5; md_data = 32'hAA; md_pc = 32'h950;
        step();
        md_valid = 0;
        n_cmp++;
        if (md_ready !== 1'b0) begin
            n_bad++; $display("FAIL arb_ready_low: got %0b want 0", md_ready);
        end
        waited = 0;
        while (stall_req !== 1'b1 && waited < 20) begin
            alu(5'd10, 32'(waited), 32'h404 + 32'(waited));
            step();
            waited++;
            n_cmp++;
            if (dut_word() !== mdl_word()) begin
                n_bad++; $display("FAIL arb_model: got %h want %h", dut_word(), mdl_word());
            end
        end
        n_cmp++;
        if (waited != LIMIT) begin
            n_bad++; $display("FAIL arb_starve_time: got %0d cycles want %0d", waited, LIMIT);
        end
        idle();
        step();
        n_cmp++;
        if ({writeEnabled, registerId, writeInput, stall_req, md_ready} !==
            {1'b1, 5'd5, 32'hAA, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL arb_drain: got we=%0b rd=%0d wd=%h st=%0b rdy=%0b want 1/5/aa/0/1",
                              writeEnabled, registerId, writeInput, stall_req, md_ready);
        end
    endtask

    task automatic test_squash();
        alu(5'd3, 32'h3, 32'h500);
        md_valid = 1; md_dest = 5'd9; md_data = 32'h55; md_pc = 32'h990;
        step();
        md_valid = 0;
        alu(5'd9, 32'h1, 32'h504);
        step();
        idle();
        n_cmp++;
        if ({writeEnabled, registerId, writeInput, md_squash} !== {1'b1, 5'd9, 32'h1, 1'b1}) begin
            n_bad++; $display("FAIL squash_hit: got we=%0b rd=%0d wd=%h sq=%0b want 1/9/1/1",
                              writeEnabled, registerId, writeInput, md_squash);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ((writeEnabled && registerId == 5'd9) || md_squash !== 1'b0 || dut_word() !== mdl_word()) begin
                n_bad++; $display("FAIL squash_after_%0d: got %h want %h", i, dut_word(), mdl_word());
            end
        end
    endtask

    task automatic test_same_cycle();
        alu(5'd7, 32'h70, 32'h600);
        md_valid = 1; md_dest = 5'd7; md_data = 32'hEE; md_pc = 32'h9A0;
        step();
        md_valid = 0;
        idle();
        n_cmp++;
        if ({writeEnabled, registerId, md_squash, md_ready} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL same_cycle_accept: got we=%0b rd=%0d sq=%0b rdy=%0b want 1/7/0/0",
                              writeEnabled, registerId, md_squash, md_ready);
        end
        step();
        n_cmp++;
        if ({writeEnabled, registerId, writeInput} !== {1'b1, 5'd7, 32'hEE}) begin
            n_bad++; $display("FAIL same_cycle_drain: got we=%0b rd=%0d wd=%h want 1/7/ee",
                              writeEnabled, registerId, writeInput);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mem_valid    = ($urandom_range(0, 9) < 7);
            mem_we       = ($urandom_range(0, 9) < 8);
            mem_dest     = 5'($urandom_range(0, 7));
            mem_result   = $urandom;
            mem_isLoad   = ($urandom_range(0, 9) < 3);
            mem_loadType = 3'($urandom_range(0, 4));
            mem_addrLow  = 2'($urandom_range(0, 3));
            mem_readData = $urandom;
            mem_pc       = $urandom;
            md_valid     = ($urandom_range(0, 9) < 4);
            md_dest      = 5'($urandom_range(1, 7));
            md_data      = $urandom;
            md_pc        = $urandom;
            step();
            n_cmp++;
            if (dut_word() !== mdl_word()) begin
                n_bad++; $display("FAIL random_%0d: got %h want %h", i, dut_word(), mdl_word());
            end
        end
        idle();
        repeat (LIMIT + 2) step();
    endtask

    task automatic test_reset_mid();
        alu(5'd3, 32'h3, 32'h700);
        md_valid = 1; md_dest = 5'd4; md_data = 32'h44; md_pc = 32'h9B0;
        step();
        md_valid = 0;
        alu(5'd11, 32'hB, 32'h704);
        step();
        reset = 0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_word() !== 73'd0) begin
            n_bad++; $display("FAIL reset_mid_async: got %h want 0", dut_word());
        end
        idle();
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
        for (int i = 0; i < LIMIT + 3; i++) begin
            step();
            n_cmp++;
            if (writeEnabled !== 1'b0 || dut_word() !== mdl_word()) begin
                n_bad++; $display("FAIL reset_mid_stale_%0d: got %h want %h", i, dut_word(), mdl_word());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_zero_dest();
        test_arbitration();
        test_squash();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
